// File: rtl/v_serial_packer.sv
// v_serial_packer: serial-to-parallel packer feeding a small word FIFO.
//
// Serial bits are shifted LSB-first into a 2*WIDTH-bit word. A completed word,
// or a zero-padded partial word requested by flush, is pushed into a
// DEPTH-entry FIFO. The FIFO is drained over a valid/ready handshake.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   a         in   serial data bit
//   a_valid   in   a is valid this cycle
//   a_ready   out  packer accepts a this cycle (registered state only)
//   flush     in   one-cycle request to emit the current partial word
//   d         out  FIFO head word (2*WIDTH bits)
//   d_partial out  head word came from a flush (upper bits zero-padded)
//   d_valid   out  FIFO non-empty
//   d_ready   in   consumer takes the head word
//   level     out  FIFO occupancy, 0..DEPTH
//   words     out  count of popped words, wraps at 4096
module v_serial_packer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic               flush,
  output logic [2*WIDTH-1:0] d,
  output logic               d_partial,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [LW-1:0]      level,
  output logic [11:0]        words
);

  localparam int unsigned WW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WW);
  localparam int unsigned PW = LW - 1;

  localparam logic [CW-1:0] LastCnt = CW'(WW - 1);
  localparam logic [LW-1:0] DepthL  = LW'(DEPTH);

  logic [WW-1:0] shift_q, shift_d, shift_in;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [WW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] part_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [11:0]   words_q;

  logic accept, word_full, flush_push, push, pop;

  // A completing bit is held off while the FIFO is full, so a push never
  // meets a full FIFO.
  assign a_ready    = ~flush_pend_q & ~((bit_cnt_q == LastCnt) & (level_q == DepthL));
  assign accept     = a_valid & a_ready;
  assign word_full  = accept & (bit_cnt_q == LastCnt);
  // flush_pend blocks bit accepts, so the two push sources are exclusive.
  assign flush_push = flush_pend_q & (level_q != DepthL);
  assign push       = word_full | flush_push;
  assign pop        = d_valid & d_ready;

  assign d         = mem_q[rd_ptr_q];
  assign d_partial = part_q[rd_ptr_q];
  assign d_valid   = (level_q != '0);
  assign level     = level_q;
  assign words     = words_q;

  // Shift word with this cycle's accepted bit merged in.
  always_comb begin
    shift_in = shift_q;
    if (accept) begin
      shift_in[bit_cnt_q] = a;
    end
  end

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    flush_pend_d = flush_pend_q;
    if (push) begin
      shift_d      = '0;
      bit_cnt_d    = '0;
      flush_pend_d = 1'b0;
    end else if (accept) begin
      shift_d   = shift_in;
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
    // Evaluated after the same-cycle accept; an empty word makes flush a no-op.
    if (flush && (bit_cnt_d != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      part_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      words_q      <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      flush_pend_q <= flush_pend_d;
      level_q      <= level_d;
      if (push) begin
        mem_q[wr_ptr_q]  <= shift_in;
        part_q[wr_ptr_q] <= flush_push;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        words_q  <= words_q + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_v_serial_packer.sv
module tb_v_serial_packer;

  logic       clk;
  logic       rst_n;

  // Main instance: WIDTH=4, DEPTH=2 (8-bit words).
  logic       a, a_valid, a_ready, flush, d_partial, d_valid, d_ready;
  logic [7:0] d;
  logic [1:0] level;
  logic [11:0] words;

  // Wrap instance: WIDTH=1, DEPTH=2 (2-bit words).
  logic       a2, a2_valid, a2_ready, flush2, d2_partial, d2_valid, d2_ready;
  logic [1:0] d2;
  logic [1:0] level2;
  logic [11:0] words2;

  int n_checks = 0;
  int n_fail   = 0;

  v_serial_packer #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .flush(flush), .d(d), .d_partial(d_partial), .d_valid(d_valid),
    .d_ready(d_ready), .level(level), .words(words)
  );

  v_serial_packer #(.WIDTH(1), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .a_valid(a2_valid), .a_ready(a2_ready),
    .flush(flush2), .d(d2), .d_partial(d2_partial), .d_valid(d2_valid),
    .d_ready(d2_ready), .level(level2), .words(words2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [23:0] stim;
  logic [15:0] stim16;
  logic [1:0]  v;

  initial begin
    rst_n = 1'b1;
    a = 0; a_valid = 0; flush = 0; d_ready = 0;
    a2 = 0; a2_valid = 0; flush2 = 0; d2_ready = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst a_ready", a_ready, 1);
    check("rst d", d, 0);
    check("rst d_partial", d_partial, 0);
    check("rst d_valid", d_valid, 0);
    check("rst level", level, 0);
    check("rst words", words, 0);
    rst_n = 1'b1;

    // Basic word: 1,0,1,1,0,0,1,0 LSB-first -> 0x4D.
    pat = 8'h4D;
    d_ready = 1; a_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a = pat[i];
      if (i == 7) check("basic no early valid", d_valid, 0);
      tick();
    end
    a_valid = 0;
    check("basic d_valid", d_valid, 1);
    check("basic d", d, 8'h4D);
    check("basic d_partial", d_partial, 0);
    tick();
    check("basic one-cycle valid", d_valid, 0);
    check("basic words", words, 1);

    // Backpressure: two full words queued, third stalls at its last bit.
    stim = {8'h96, 8'h3C, 8'hA5};
    d_ready = 0; a_valid = 1;
    for (int i = 0; i < 23; i++) begin
      a = stim[i];
      tick();
      if (i == 15) check("bp level full", level, 2);
    end
    a = stim[23];
    check("bp a_ready stall", a_ready, 0);
    check("bp head held", d, 8'hA5);
    tick();
    check("bp no push when full", level, 2);
    d_ready = 1;
    tick();
    d_ready = 0;
    check("bp level after pop", level, 1);
    check("bp a_ready release", a_ready, 1);
    check("bp next head", d, 8'h3C);
    check("bp words", words, 2);
    tick();
    check("bp 24th accepted", level, 2);
    check("bp a_ready after word", a_ready, 1);
    a_valid = 0; d_ready = 1;
    tick();
    check("bp third word", d, 8'h96);
    check("bp third partial", d_partial, 0);
    tick();
    check("bp drained", level, 0);
    check("bp words 4", words, 4);

    // Flush partial: bits 1,1,1 then flush -> 0x07 partial two cycles later.
    a_valid = 1; a = 1;
    repeat (3) tick();
    a_valid = 0; flush = 1;
    tick();
    flush = 0;
    check("fl a_ready pend", a_ready, 0);
    check("fl not yet valid", d_valid, 0);
    tick();
    check("fl d_valid", d_valid, 1);
    check("fl d", d, 8'h07);
    check("fl d_partial", d_partial, 1);
    pat = 8'h5A;
    a_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a = pat[i];
      tick();
    end
    a_valid = 0;
    check("fl next word", d, 8'h5A);
    check("fl next partial", d_partial, 0);
    check("fl next level", level, 1);
    tick();
    check("fl words", words, 6);
    flush = 1;
    tick();
    flush = 0;
    check("fl empty no-op a_ready", a_ready, 1);
    tick();
    check("fl empty no-op valid", d_valid, 0);

    // Flush when full: partial is held until the FIFO has room.
    stim16 = {8'h22, 8'h11};
    d_ready = 0; a_valid = 1;
    for (int i = 0; i < 16; i++) begin
      a = stim16[i];
      tick();
    end
    pat = 8'h05;
    for (int i = 0; i < 3; i++) begin
      a = pat[i];
      tick();
    end
    a_valid = 0; flush = 1;
    tick();
    flush = 0;
    check("ff a_ready pend", a_ready, 0);
    check("ff level", level, 2);
    tick();
    check("ff no push", level, 2);
    d_ready = 1;
    tick();
    d_ready = 0;
    check("ff level after pop", level, 1);
    check("ff head", d, 8'h22);
    tick();
    check("ff partial pushed", level, 2);
    check("ff a_ready back", a_ready, 1);
    d_ready = 1;
    tick();
    check("ff partial d", d, 8'h05);
    check("ff partial flag", d_partial, 1);
    tick();
    check("ff drained", d_valid, 0);
    check("ff words", words, 9);

    // Reset mid-word with one word queued.
    d_ready = 0; a_valid = 1;
    pat = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      a = pat[i];
      tick();
    end
    a = 1;
    repeat (5) tick();
    a_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("mr level", level, 0);
    check("mr d_valid", d_valid, 0);
    check("mr d", d, 0);
    check("mr d_partial", d_partial, 0);
    check("mr words", words, 0);
    check("mr a_ready", a_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_ready = 1; a_valid = 1; a = 1;
    repeat (8) tick();
    a_valid = 0;
    check("mr word ff", d, 8'hFF);
    check("mr word partial", d_partial, 0);
    check("mr word level", level, 1);
    tick();
    check("mr words 1", words, 1);

    // Counter wrap on the WIDTH=1 instance: level held at 1 by push+pop.
    a2_valid = 1; a2 = 0;
    repeat (2) tick();
    check("wr prefill level", level2, 1);
    for (int i = 1; i <= 4096; i++) begin
      v = i[1:0];
      a2 = v[0]; d2_ready = 0;
      tick();
      a2 = v[1]; d2_ready = 1;
      v = v - 2'd1;
      check("wr head", d2, {30'b0, v});
      tick();
      check("wr level", level2, 1);
      if (i == 4095) check("wr words 4095", words2, 12'hFFF);
    end
    a2_valid = 0; d2_ready = 0;
    check("wr words wrap", words2, 0);
    check("wr last word", d2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
